// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits, each CLK_DIV cycles.
// tx falls the cycle after the handshake; tx_ready stays low for the whole frame, so the next word waits.
module uart_tx #(
   parameter int CLK_DIV   = 868,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 busy,
   output logic                 tx
);

   localparam int BAUD_W = $clog2(CLK_DIV);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  tx_ready_q, tx_ready_d;
   logic                  busy_q, busy_d;
   logic                  baud_end;

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      baud_end = (baud_q == BAUD_LAST);
      baud_d   = baud_end ? '0 : baud_q + BAUD_W'(1);

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (tx_valid && tx_ready_q) begin
               shift_d = tx_data;
               par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         S_PAR: begin
            if (baud_end) begin
               bit_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: begin
            baud_d  = '0;
            bit_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so the pins are plain flops.
      tx_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         S_PAR:   tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations side by side, checked every cycle against a frame-level model.
module tb_uart_tx;

   localparam int NI = 4;
   localparam int CD [NI] = '{4, 4, 4, 3};
   localparam int DB [NI] = '{8, 8, 8, 7};
   localparam int PB [NI] = '{0, 2, 1, 0};
   localparam int SB [NI] = '{1, 1, 1, 2};

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din [NI];
   logic       vld [NI];
   logic       rdy [NI];
   logic       bsy [NI];
   logic       txo [NI];

   always #5 clk = ~clk;

   uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .tx_data(din[0]), .tx_valid(vld[0]),
      .tx_ready(rdy[0]), .busy(bsy[0]), .tx(txo[0]));
   uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
      .clk(clk), .rst(rst), .tx_data(din[1]), .tx_valid(vld[1]),
      .tx_ready(rdy[1]), .busy(bsy[1]), .tx(txo[1]));
   uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
      .clk(clk), .rst(rst), .tx_data(din[2]), .tx_valid(vld[2]),
      .tx_ready(rdy[2]), .busy(bsy[2]), .tx(txo[2]));
   uart_tx #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
      .clk(clk), .rst(rst), .tx_data(din[3][6:0]), .tx_valid(vld[3]),
      .tx_ready(rdy[3]), .busy(bsy[3]), .tx(txo[3]));

   // Model: one queue entry per line cycle of the frame in flight; empty queue means idle.
   bit expq [NI][$];
   bit mready [NI];
   int n_checks = 0;
   int n_pass   = 0;

   function automatic int nbits(int i);
      return 1 + DB[i] + ((PB[i] != 0) ? 1 : 0) + SB[i];
   endfunction

   function automatic void push_frame(int i, logic [7:0] d);
      bit bits[$];
      bit p;
      p = 1'b0;
      bits.push_back(1'b0);
      for (int j = 0; j < DB[i]; j++) begin
         bits.push_back(d[j]);
         p ^= d[j];
      end
      if (PB[i] == 1) bits.push_back(~p);
      else if (PB[i] == 2) bits.push_back(p);
      for (int s = 0; s < SB[i]; s++) bits.push_back(1'b1);
      foreach (bits[k]) repeat (CD[i]) expq[i].push_back(bits[k]);
   endfunction

   task automatic chk(string name, int i, logic got, logic exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s inst=%0d got=%b expected=%b at %0t", name, i, got, exp, $time);
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         bit hs;
         if (rst) begin
            expq[i].delete();
            mready[i] = 1'b0;
         end else begin
            hs = vld[i] && mready[i] && (expq[i].size() == 0);
            if (expq[i].size() != 0) void'(expq[i].pop_front());
            if (hs) push_frame(i, din[i]);
            mready[i] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         logic etx, erdy, ebsy;
         if (rst) begin
            etx = 1'b1; erdy = 1'b0; ebsy = 1'b0;
         end else if (expq[i].size() != 0) begin
            etx = expq[i][0]; erdy = 1'b0; ebsy = 1'b1;
         end else begin
            etx = 1'b1; erdy = mready[i]; ebsy = 1'b0;
         end
         chk("tx", i, txo[i], etx);
         chk("tx_ready", i, rdy[i], erdy);
         chk("busy", i, bsy[i], ebsy);
      end
   end

   // Hand-derived frames, bit k of each word is frame bit k (start bit at k = 0).
   logic [10:0] lit [NI];

   initial begin
      lit[0] = 11'b01101001010;   // 0xA5 8N1
      lit[1] = 11'b11000001110;   // 0x07 even parity -> 1
      lit[2] = 11'b10000001110;   // 0x07 odd parity  -> 0
      lit[3] = 11'b01110101010;   // 0x55 7 bits, 2 stop
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         vld[i] = 1'b0;
         din[i] = 8'h00;
      end

      repeat (3) begin
         @(negedge clk);
         chk("rst_tx", 0, txo[0], 1'b1);
         chk("rst_ready", 0, rdy[0], 1'b0);
         chk("rst_busy", 0, bsy[0], 1'b0);
      end
      #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) chk("ready_after_rst", i, rdy[i], 1'b1);

      // Directed frames on all four configurations at once.
      #1;
      for (int i = 0; i < NI; i++) vld[i] = 1'b1;
      din[0] = 8'hA5; din[1] = 8'h07; din[2] = 8'h07; din[3] = 8'hD5;
      for (int rel = 1; rel <= 46; rel++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            int n;
            n = nbits(i);
            if (((rel - 1) % CD[i]) == CD[i] / 2 && ((rel - 1) / CD[i]) < n)
               chk("frame_bit", i, txo[i], lit[i][(rel - 1) / CD[i]]);
            if (rel == n * CD[i]) begin
               chk("busy_last_stop", i, bsy[i], 1'b1);
               chk("ready_last_stop", i, rdy[i], 1'b0);
            end
            if (rel == n * CD[i] + 1) begin
               chk("ready_after_frame", i, rdy[i], 1'b1);
               chk("busy_after_frame", i, bsy[i], 1'b0);
            end
         end
         if (rel == 1) begin
            #1;
            for (int i = 0; i < NI; i++) vld[i] = 1'b0;
         end
      end

      // Back-to-back 0x00 then 0xFF with tx_valid held; data changes mid-frame.
      #1 vld[0] = 1'b1; din[0] = 8'h00;
      for (int rel = 1; rel <= 42; rel++) begin
         @(negedge clk);
         if (rel == 6)  chk("b2b_data_held", 0, txo[0], 1'b0);
         if (rel == 41) begin
            chk("b2b_gap_tx", 0, txo[0], 1'b1);
            chk("b2b_gap_ready", 0, rdy[0], 1'b1);
         end
         if (rel == 42) begin
            chk("b2b_second_start", 0, txo[0], 1'b0);
            chk("b2b_second_busy", 0, bsy[0], 1'b1);
         end
         if (rel == 1) #1 din[0] = 8'hFF;
      end
      #1 vld[0] = 1'b0;
      repeat (45) @(negedge clk);

      // Reset during data bit 3 of 0xC3, then a clean 0x3C.
      #1 vld[0] = 1'b1; din[0] = 8'hC3;
      for (int rel = 1; rel <= 18; rel++) begin
         @(negedge clk);
         if (rel == 1) #1 vld[0] = 1'b0;
      end
      chk("bit3_before_rst", 0, txo[0], 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_tx", 0, txo[0], 1'b1);
      chk("async_rst_busy", 0, bsy[0], 1'b0);
      chk("async_rst_ready", 0, rdy[0], 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_abort", 0, rdy[0], 1'b1);
      #1 vld[0] = 1'b1; din[0] = 8'h3C;
      @(negedge clk);
      #1 vld[0] = 1'b0;
      repeat (45) @(negedge clk);

      // Reset and handshake on the same edge: no frame.
      #1 rst = 1'b1; vld[0] = 1'b1; din[0] = 8'h5A;
      @(negedge clk);
      #1 rst = 1'b0; vld[0] = 1'b0;
      @(negedge clk);
      chk("rst_wins_busy", 0, bsy[0], 1'b0);
      chk("rst_wins_tx", 0, txo[0], 1'b1);
      repeat (4) @(negedge clk);

      // Random traffic with occasional one-cycle resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         #1;
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 499) == 0) rst = 1'b1;
         for (int i = 0; i < NI; i++) begin
            vld[i] = ($urandom_range(0, 2) != 0);
            din[i] = 8'($urandom);
         end
      end
      #1 rst = 1'b0;
      for (int i = 0; i < NI; i++) vld[i] = 1'b0;
      repeat (60) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
